zjh_mux_scheduler: RTL and testbench



---
 rtl/zjh_mux_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_zjh_mux_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zjh_mux_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : zjh_mux_scheduler
//  Purpose  : Round-robin scheduler sharing one 74HC153-style 4:1 mux among
//             four requesters. Drives Sel / active-low Enable with
//             break-before-make and settle timing, samples the mux output and
//             hands the granted requester a registered bit plus valid strobe.
//  Options  : ZJH_SCHED_PRIO0_EN - Req[0] gets fixed top priority and may cut
//             another requester's HOLD short (pointer untouched by such grants).
//  Revision : 1.0 - initial release
// ============================================================================
module zjh_mux_scheduler #(
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Req,
  input  logic       MuxOut,
  output logic [1:0] Sel,
  output logic       Enable,
  output logic [3:0] Grant,
  output logic       DataOut,
  output logic       DataValid,
  output logic       Busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             enable_q, enable_d;
  logic [3:0]       grant_q, grant_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       arb_idx;
  logic             arb_valid;
  logic             arb_prio;
  logic             prio_cut;
  logic             req_granted;

  // Arbitration: first set request scanning upward from pointer+1 with wrap
  always_comb begin
    logic [1:0] cand;
    arb_idx   = 2'd0;
    arb_valid = 1'b0;
    arb_prio  = 1'b0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!arb_valid && Req[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
`ifdef ZJH_SCHED_PRIO0_EN
    if (Req[0]) begin
      arb_valid = 1'b1;
      arb_idx   = 2'd0;
      arb_prio  = 1'b1;
    end
`endif
  end

  // A priority requester may pre-empt someone else's HOLD
`ifdef ZJH_SCHED_PRIO0_EN
  assign prio_cut = Req[0] && (sel_q != 2'd0);
`else
  assign prio_cut = 1'b0;
`endif

  // Sel still names the granted requester while a grant is live
  assign req_granted = Req[sel_q];

  // Next-state and next-output computation
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    enable_d = enable_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        // Mux stays disabled until a fresh grant; Sel only moves here,
        // while Enable is high, so break-before-make holds by construction.
        state_d  = S_IDLE;
        enable_d = 1'b1;
        grant_d  = 4'b0000;
        cnt_d    = '0;
        if (arb_valid) begin
          state_d  = S_SETTLE;
          sel_d    = arb_idx;
          grant_d  = 4'b0001 << arb_idx;
          enable_d = 1'b0;
          if (!arb_prio) ptr_d = arb_idx;
        end
      end
      S_SETTLE: begin
        if (!req_granted) begin
          state_d  = S_GAP;
          enable_d = 1'b1;
          grant_d  = 4'b0000;
          cnt_d    = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        // Every HOLD cycle yields a sample, including the one that ends it
        dout_d   = MuxOut;
        dvalid_d = 1'b1;
        if (!req_granted || (cnt_q == HOLD_LAST) || prio_cut) begin
          state_d  = S_GAP;
          enable_d = 1'b1;
          grant_d  = 4'b0000;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        enable_d = 1'b1;
        grant_d  = 4'b0000;
        cnt_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 2'd0;
      enable_q <= 1'b1;
      grant_q  <= 4'b0000;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ptr_q    <= 2'd3;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      grant_q  <= grant_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Sel       = sel_q;
  assign Enable    = enable_q;
  assign Grant     = grant_q;
  assign DataOut   = dout_q;
  assign DataValid = dvalid_q;
  assign Busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_zjh_mux_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zjh_mux_scheduler
//  Purpose  : Self-checking bench for zjh_mux_scheduler using a grant-timeline
//             reference model and scenario tasks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_zjh_mux_scheduler;

  localparam int SETTLE = 2;
  localparam int HOLD   = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       mux;
  logic [1:0] Sel;
  logic       Enable;
  logic [3:0] Grant;
  logic       DataOut;
  logic       DataValid;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  zjh_mux_scheduler #(.SETTLE_CYC(SETTLE), .HOLD_CYC(HOLD), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Req(req), .MuxOut(mux),
    .Sel(Sel), .Enable(Enable), .Grant(Grant),
    .DataOut(DataOut), .DataValid(DataValid), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a grant is a timeline of SETTLE settle cycles followed by
  // up to HOLD sampled cycles, then one gap cycle.
  bit         m_active;
  bit         m_gap;
  int         m_ptr;
  int         m_idx;
  int         m_age;
  int         m_samples;
  logic [1:0] e_sel;
  logic       e_en;
  logic [3:0] e_grant;
  logic       e_dout;
  logic       e_dval;
  logic       e_busy;

  localparam logic [9:0] RESET_VEC = {2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};

  logic [9:0] obs, expv;
  assign obs  = {Sel, Enable, Grant, (DataValid ? DataOut : 1'b0), DataValid, Busy};
  assign expv = {e_sel, e_en, e_grant, (e_dval ? e_dout : 1'b0), e_dval, e_busy};

  task automatic model_reset();
    m_active = 0; m_gap = 0; m_ptr = 3; m_idx = 0; m_age = 0; m_samples = 0;
    e_sel = 2'b00; e_en = 1'b1; e_grant = 4'b0000;
    e_dout = 1'b0; e_dval = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_edge();
    int  pick;
    bit  nd;
    bit  fin;
    nd = 0; fin = 0;
    if (m_active) begin
      if (m_age < SETTLE) begin
        if (!req[m_idx]) fin = 1; else m_age++;
      end else begin
        e_dout = mux;
        nd = 1;
        m_samples++;
        if (!req[m_idx] || m_samples == HOLD) fin = 1; else m_age++;
      end
      if (fin) begin
        m_active = 0; m_gap = 1; e_en = 1'b1; e_grant = 4'b0000;
      end
    end else begin
      m_gap = 0;
      if (req != 4'b0000) begin
        pick = -1;
        for (int k = 1; k <= 4; k++)
          if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
        m_active = 1; m_idx = pick; m_age = 0; m_samples = 0; m_ptr = pick;
        e_sel = 2'(pick); e_grant = 4'(1 << pick); e_en = 1'b0;
      end
    end
    e_dval = nd;
    e_busy = m_active || m_gap;
  endtask

  // One clock: model sees the same inputs as the DUT at the edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    mux = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset_values obs=%b exp=%b", obs, RESET_VEC);
    end
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL idle_no_req obs=%b exp=%b", obs, expv);
      end
    end
  endtask

  task automatic test_single_requester();
    int n, vcount, en_hi;
    bit seen;
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if ({Grant, Sel, Enable} !== {4'b0001, 2'd0, 1'b0}) begin
      errors++; $display("FAIL single_grant got=%b/%0d/%b want=0001/0/0", Grant, Sel, Enable);
    end
    n = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(); n++;
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL single_model obs=%b exp=%b", obs, expv);
      end
      if (DataValid) seen = 1;
    end
    checks++;
    if (!seen || n != 3) begin
      errors++; $display("FAIL single_first_valid got=%0d cycles want=3", n);
    end
    vcount = 1; en_hi = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL single_model obs=%b exp=%b", obs, expv);
      end
      if (Enable) en_hi++;
      if (DataValid) vcount++; else seen = 1;
    end
    checks++;
    if (vcount != HOLD || en_hi != 1 || Grant !== 4'b0001) begin
      errors++;
      $display("FAIL single_samples_gap got=%0d valid,%0d gap,grant=%b want=8,1,0001",
               vcount, en_hi, Grant);
    end
  endtask

  task automatic test_all_requesters();
    logic [3:0] prev;
    logic [3:0] gseq [5];
    logic [1:0] sseq [5];
    int ng;
    do_reset();
    req = 4'b1111;
    prev = 4'b0000; ng = 0;
    for (int i = 0; i < 80 && ng < 5; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL all_model obs=%b exp=%b", obs, expv);
      end
      if (Grant != 4'b0000 && prev == 4'b0000) begin
        gseq[ng] = Grant; sseq[ng] = Sel; ng++;
      end
      prev = Grant;
    end
    checks++;
    if (ng != 5) begin
      errors++; $display("FAIL all_grant_count got=%0d want=5", ng);
    end
    for (int i = 0; i < ng; i++) begin
      checks++;
      if (gseq[i] !== 4'(1 << (i % 4)) || sseq[i] !== 2'(i % 4)) begin
        errors++;
        $display("FAIL all_order[%0d] got=%b/%0d want=%b/%0d", i, gseq[i], sseq[i],
                 4'(1 << (i % 4)), i % 4);
      end
    end
  endtask

  task automatic test_drop_in_hold();
    int nvalid;
    do_reset();
    req = 4'b0100;
    nvalid = 0;
    for (int i = 0; i < 20 && nvalid < 3; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL hold_drop_model obs=%b exp=%b", obs, expv);
      end
      if (DataValid) nvalid++;
    end
    req = 4'b0000;
    tick();
    if (DataValid) nvalid++;
    checks++;
    if (Grant !== 4'b0000 || Enable !== 1'b1 || Busy !== 1'b1) begin
      errors++; $display("FAIL hold_drop_gap got=%b/%b/%b want=0000/1/1", Grant, Enable, Busy);
    end
    repeat (4) begin
      tick();
      if (DataValid) nvalid++;
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL hold_drop_model obs=%b exp=%b", obs, expv);
      end
    end
    checks++;
    if (nvalid != m_samples || m_samples != 4) begin
      errors++; $display("FAIL hold_drop_samples got=%0d want=%0d", nvalid, m_samples);
    end
  endtask

  task automatic test_drop_in_settle();
    bit sawv;
    do_reset();
    req = 4'b0010;
    tick();
    checks++;
    if (Grant !== 4'b0010 || Sel !== 2'd1) begin
      errors++; $display("FAIL settle_grant got=%b/%0d want=0010/1", Grant, Sel);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (Grant !== 4'b0000 || Enable !== 1'b1) begin
      errors++; $display("FAIL settle_drop_gap got=%b/%b want=0000/1", Grant, Enable);
    end
    sawv = DataValid;
    repeat (5) begin
      tick();
      if (DataValid) sawv = 1;
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL settle_drop_model obs=%b exp=%b", obs, expv);
      end
    end
    checks++;
    if (sawv) begin
      errors++; $display("FAIL settle_drop_valid got=1 want=0");
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    req = 4'b1000;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (DataValid) seen = 1;
    end
    checks++;
    if (!seen || Sel !== 2'd3 || Enable !== 1'b0) begin
      errors++; $display("FAIL areset_hold_setup got=sel %0d en %b want=sel 3 en 0", Sel, Enable);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL areset_immediate obs=%b exp=%b", obs, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req = 4'b1111;
    tick();
    checks++;
    if (Grant !== 4'b0001 || Sel !== 2'd0) begin
      errors++; $display("FAIL areset_next_grant got=%b want=0001", Grant);
    end
  endtask

  task automatic test_prio0();
    int  vcount;
    bit  seen, done;
    do_reset();
    req = 4'b0100;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (DataValid) seen = 1;
    end
    vcount = seen ? 1 : 0;
    req = 4'b0101;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (Grant == 4'b0001) done = 1;
      else if (DataValid) vcount++;
    end
    checks++;
`ifdef ZJH_SCHED_PRIO0_EN
    if (!done || vcount >= HOLD) begin
      errors++; $display("FAIL prio0_cut got=%0d samples,done=%0d want<8,1", vcount, done);
    end
`else
    if (!done || vcount != HOLD) begin
      errors++; $display("FAIL prio0_rr got=%0d samples,done=%0d want=8,1", vcount, done);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) req = 4'($urandom);
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random_cyc%0d req=%b obs=%b exp=%b", i, req, obs, expv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    mux = 1'b0;
    model_reset();
    test_reset();
    test_single_requester();
    test_all_requesters();
    test_drop_in_hold();
    test_drop_in_settle();
    test_async_reset();
    test_prio0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
